// File: rtl/rot13_seq_arbiter.sv
// rot13_seq_arbiter
// Shares one nibble-loaded rot13 datapath between two byte requesters.
// Round-robin grant, three-step datapath drive (load low, load high,
// convert), capture, then a response handshake carrying the requester id.
// Optional feature: define ROT13_SEQ_ACK_CHECK_EN to check the datapath's
// acknowledge patterns (0x0F after the low load, 0xF0 after the high load)
// and raise a sticky err on mismatch.
//
// Handshake semantics: a transfer happens on a rising clk edge where both
// valid and ready are high. A requester holds req_valid and its data stable
// until it sees its req_ready bit; the response side holds rsp_valid,
// rsp_data and rsp_id stable until rsp_ready is seen.
module rot13_seq_arbiter #(
    parameter bit BYPASS_HI = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_valid,
    input  logic [7:0] req_data0,
    input  logic [7:0] req_data1,
    output logic [1:0] req_ready,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_id,
    output logic       busy,
    output logic       dp_rst,
    output logic [1:0] dp_ctl,
    output logic [3:0] dp_data,
    input  logic [7:0] dp_out,
    output logic       err,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LO   = 3'd1,
        S_HI   = 3'd2,
        S_CONV = 3'd3,
        S_CAP  = 3'd4,
        S_RESP = 3'd5
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] cur;
    logic       last;
    logic       grant_id;
    logic       grant_fire;
    logic       grant_bypass;
    logic [7:0] grant_byte;
    logic       ack_bad;

    // Round-robin choice: on contention the requester not served last wins.
    always_comb begin
        grant_id = req_valid[1];
        if (req_valid == 2'b11) begin
            grant_id = ~last;
        end
    end

    assign grant_byte   = grant_id ? req_data1 : req_data0;
    assign grant_fire   = (state == S_IDLE) && (req_valid != 2'b00) && !reset;
    assign grant_bypass = BYPASS_HI && grant_byte[7];

    // One-hot accept toward the granted requester, only while idle.
    always_comb begin
        req_ready = 2'b00;
        if (grant_fire) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: fixed walk through the datapath steps, or straight to RESP on bypass.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (grant_fire) begin
                    state_next = grant_bypass ? S_RESP : S_LO;
                end
            end
            S_LO:   state_next = S_HI;
            S_HI:   state_next = S_CONV;
            S_CONV: state_next = S_CAP;
            S_CAP:  state_next = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State-decoded outputs: datapath control and nibble, status flags.
    always_comb begin
        dp_ctl  = 2'b10;
        dp_data = 4'h0;
        case (state)
            S_LO: begin
                dp_ctl  = 2'b00;
                dp_data = cur[3:0];
            end
            S_HI: begin
                dp_ctl  = 2'b01;
                dp_data = cur[7:4];
            end
            default: begin
                dp_ctl  = 2'b10;
                dp_data = 4'h0;
            end
        endcase
    end

    assign rsp_valid = (state == S_RESP);
    assign busy      = (state != S_IDLE);
    assign dp_rst    = reset;
    assign dbg_state = state;

    // Grant bookkeeping: latch the accepted byte, its requester and the rr pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur    <= 8'h00;
            last   <= 1'b1;
            rsp_id <= 1'b0;
        end else if (grant_fire) begin
            cur    <= grant_byte;
            last   <= grant_id;
            rsp_id <= grant_id;
        end
    end

`ifdef ROT13_SEQ_ACK_CHECK_EN
    logic ack_miss;
    logic err_q;

    // Acknowledge pattern compare in the two states where the datapath reports progress.
    always_comb begin
        ack_miss = ((state == S_HI)   && (dp_out != 8'h0F)) ||
                   ((state == S_CONV) && (dp_out != 8'hF0));
    end

    // Per-transaction poison flag plus the sticky error seen by the outside.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_bad <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (grant_fire) begin
                ack_bad <= 1'b0;
            end else if (ack_miss) begin
                ack_bad <= 1'b1;
            end
            if (ack_miss) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign ack_bad = 1'b0;
    assign err     = 1'b0;
`endif

    // Response byte: raw byte on bypass grant, datapath result in CAP.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_data <= 8'h00;
        end else if (grant_fire && grant_bypass) begin
            rsp_data <= grant_byte;
        end else if (state == S_CAP) begin
            rsp_data <= ack_bad ? 8'h00 : dp_out;
        end
    end

endmodule

// File: tb/tb_rot13_seq_arbiter.sv
// Bench for rot13_seq_arbiter: table of directed transactions, hand-written
// multi-cycle sequences, then randomized traffic against a reference model.
// Honors ROT13_SEQ_ACK_CHECK_EN to pick expectations for the ack-check case.
module tb_rot13_seq_arbiter;

    localparam bit BYP = 1'b1;
`ifdef ROT13_SEQ_ACK_CHECK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- main DUT (BYPASS_HI = 1) ----------------
    logic [1:0] req_valid;
    logic [7:0] req_data0, req_data1;
    logic [1:0] req_ready;
    logic       rsp_valid, rsp_ready, rsp_id, busy, dp_rst, err;
    logic [7:0] rsp_data, dp_out;
    logic [1:0] dp_ctl;
    logic [3:0] dp_data;
    logic [2:0] dbg_state;

    rot13_seq_arbiter #(.BYPASS_HI(BYP)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data0(req_data0), .req_data1(req_data1),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .busy(busy), .dp_rst(dp_rst), .dp_ctl(dp_ctl), .dp_data(dp_data),
        .dp_out(dp_out), .err(err), .dbg_state(dbg_state)
    );

    // ---------------- second DUT (BYPASS_HI = 0) ----------------
    logic [1:0] nb_req_valid;
    logic [7:0] nb_req_data0, nb_req_data1;
    logic [1:0] nb_req_ready;
    logic       nb_rsp_valid, nb_rsp_ready, nb_rsp_id, nb_busy, nb_dp_rst, nb_err;
    logic [7:0] nb_rsp_data, nb_dp_out;
    logic [1:0] nb_dp_ctl;
    logic [3:0] nb_dp_data;
    logic [2:0] nb_dbg_state;

    rot13_seq_arbiter #(.BYPASS_HI(1'b0)) u_nb (
        .clk(clk), .reset(reset),
        .req_valid(nb_req_valid), .req_data0(nb_req_data0), .req_data1(nb_req_data1),
        .req_ready(nb_req_ready),
        .rsp_valid(nb_rsp_valid), .rsp_ready(nb_rsp_ready), .rsp_data(nb_rsp_data), .rsp_id(nb_rsp_id),
        .busy(nb_busy), .dp_rst(nb_dp_rst), .dp_ctl(nb_dp_ctl), .dp_data(nb_dp_data),
        .dp_out(nb_dp_out), .err(nb_err), .dbg_state(nb_dbg_state)
    );

    // ---------------- reference rot13 ----------------
    function automatic logic [7:0] ref_rot13(input logic [7:0] b);
        int v;
        v = int'(b);
        if (b[7]) return 8'h00;
        if (v >= 65 && v <= 90) return 8'((v - 65 + 13) % 26 + 65);
        if (v >= 97 && v <= 122) return 8'((v - 97 + 13) % 26 + 97);
        return b;
    endfunction

    // ---------------- datapath models ----------------
    logic       corrupt_lo;
    logic [3:0] dp_lo, dp_hi, nb_dp_lo, nb_dp_hi;

    always @(posedge clk) begin
        if (dp_rst) begin
            dp_lo <= 4'h0; dp_hi <= 4'h0; dp_out <= 8'h00;
        end else if (dp_ctl == 2'b00) begin
            dp_lo  <= dp_data;
            dp_out <= corrupt_lo ? 8'h00 : 8'h0F;
        end else if (dp_ctl == 2'b01) begin
            dp_hi  <= dp_data;
            dp_out <= 8'hF0;
        end else begin
            dp_out <= ref_rot13({dp_hi, dp_lo});
        end
    end

    always @(posedge clk) begin
        if (nb_dp_rst) begin
            nb_dp_lo <= 4'h0; nb_dp_hi <= 4'h0; nb_dp_out <= 8'h00;
        end else if (nb_dp_ctl == 2'b00) begin
            nb_dp_lo  <= nb_dp_data;
            nb_dp_out <= 8'h0F;
        end else if (nb_dp_ctl == 2'b01) begin
            nb_dp_hi  <= nb_dp_data;
            nb_dp_out <= 8'hF0;
        end else begin
            nb_dp_out <= ref_rot13({nb_dp_hi, nb_dp_lo});
        end
    end

    // ---------------- scoreboard ----------------
    int n_vec;
    int n_err;
    logic [8:0] exp_q[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic reset_dut();
        reset     = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        nb_req_valid = 2'b00;
        nb_rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One transaction on the main DUT. Caller pushes {id, data} to exp_q.
    // Called at a falling edge; returns at the falling edge after the response handshake.
    task automatic do_txn(input logic [1:0] set_v, input logic [7:0] d0, input logic [7:0] d1,
                          input logic [1:0] late_v, input logic [7:0] ld0, input logic [7:0] ld1,
                          input int exp_lat, input int stall);
        int         waited;
        logic [8:0] e;
        logic       eid;
        logic [7:0] ed, b, dd;
        logic [1:0] ec;
        if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e   = exp_q.pop_front();
        eid = e[8];
        ed  = e[7:0];
        rsp_ready = 1'b0;
        if (set_v[0]) begin req_data0 = d0; req_valid[0] = 1'b1; end
        if (set_v[1]) begin req_data1 = d1; req_valid[1] = 1'b1; end
        #1;
        waited = 0;
        while (req_ready == 2'b00 && waited < 20) begin
            @(negedge clk); #1;
            waited++;
        end
        chk("req_ready_grant", 8'(req_ready), eid ? 8'h02 : 8'h01);
        if (waited >= 20) begin
            req_valid = 2'b00;
            return;
        end
        b = eid ? req_data1 : req_data0;
        for (int k = 1; k <= exp_lat + stall + 1; k++) begin
            @(negedge clk);
            if (k < exp_lat) begin
                chk("rsp_valid_early", 8'(rsp_valid), 8'h00);
                chk("busy_mid", 8'(busy), 8'h01);
                chk("req_ready_busy", 8'(req_ready), 8'h00);
                case (k)
                    1: begin ec = 2'b00; dd = {4'h0, b[3:0]}; end
                    2: begin ec = 2'b01; dd = {4'h0, b[7:4]}; end
                    default: begin ec = 2'b10; dd = 8'h00; end
                endcase
                chk("dp_ctl_seq", 8'(dp_ctl), 8'(ec));
                chk("dp_data_seq", 8'(dp_data), dd);
            end else if (k <= exp_lat + stall) begin
                chk("rsp_valid", 8'(rsp_valid), 8'h01);
                chk("rsp_data", rsp_data, ed);
                chk("rsp_id", 8'(rsp_id), 8'(eid));
                chk("req_ready_resp", 8'(req_ready), 8'h00);
                if (exp_lat == 1 && k == 1) chk("dp_ctl_bypass", 8'(dp_ctl), 8'h02);
                if (k == exp_lat + stall) rsp_ready = 1'b1;
            end else begin
                chk("rsp_valid_after", 8'(rsp_valid), 8'h00);
                chk("busy_after", 8'(busy), 8'h00);
                rsp_ready = 1'b0;
            end
            if (k == 1) begin
                req_valid[eid] = 1'b0;
                if (late_v[0]) begin req_data0 = ld0; req_valid[0] = 1'b1; end
                if (late_v[1]) begin req_data1 = ld1; req_valid[1] = 1'b1; end
            end
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [1:0] set_v;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       exp_id;
        logic [7:0] exp_data;
        int         exp_lat;
    } vec_t;

    vec_t tbl[11];

    function automatic logic [7:0] rand_byte();
        case ($urandom_range(0, 2))
            0: return 8'($urandom_range(65, 90));
            1: return 8'($urandom_range(97, 122));
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       m_last;
        logic [1:0] pend, sv, lv;
        logic [7:0] pd0, pd1, nd0, nd1, ld0, ld1, bg, ex;
        logic       gid;
        int         lat;

        n_vec = 0; n_err = 0;
        corrupt_lo = 1'b0;
        req_data0 = 8'h00; req_data1 = 8'h00;
        nb_req_data0 = 8'h00; nb_req_data1 = 8'h00;

        //              set    d0     d1     id    data   lat
        tbl[0]  = '{2'b11, 8'h61, 8'h7A, 1'b0, 8'h6E, 5};
        tbl[1]  = '{2'b00, 8'h00, 8'h00, 1'b1, 8'h6D, 5};
        tbl[2]  = '{2'b01, 8'h41, 8'h00, 1'b0, 8'h4E, 5};
        tbl[3]  = '{2'b10, 8'h00, 8'h9C, 1'b1, 8'h9C, 1};
        tbl[4]  = '{2'b01, 8'h20, 8'h00, 1'b0, 8'h20, 5};
        tbl[5]  = '{2'b11, 8'h4D, 8'h6E, 1'b1, 8'h61, 5};
        tbl[6]  = '{2'b00, 8'h00, 8'h00, 1'b0, 8'h5A, 5};
        tbl[7]  = '{2'b10, 8'h00, 8'hFF, 1'b1, 8'hFF, 1};
        tbl[8]  = '{2'b01, 8'h39, 8'h00, 1'b0, 8'h39, 5};
        tbl[9]  = '{2'b11, 8'h80, 8'h6D, 1'b1, 8'h7A, 5};
        tbl[10] = '{2'b00, 8'h00, 8'h00, 1'b0, 8'h80, 1};

        // reset values, sampled while reset is still asserted
        reset = 1'b1;
        req_valid = 2'b00; rsp_ready = 1'b0;
        nb_req_valid = 2'b00; nb_rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", 8'(rsp_valid), 8'h00);
        chk("rst_rsp_data", rsp_data, 8'h00);
        chk("rst_rsp_id", 8'(rsp_id), 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);
        chk("rst_dp_ctl", 8'(dp_ctl), 8'h02);
        chk("rst_dp_data", 8'(dp_data), 8'h00);
        chk("rst_err", 8'(err), 8'h00);
        chk("rst_dp_rst", 8'(dp_rst), 8'h01);
        chk("rst_req_ready", 8'(req_ready), 8'h00);
        reset = 1'b0;
        #1;
        chk("dp_rst_release", 8'(dp_rst), 8'h00);
        @(negedge clk);

        // directed table
        for (int i = 0; i < 11; i++) begin
            exp_q.push_back({tbl[i].exp_id, tbl[i].exp_data});
            do_txn(tbl[i].set_v, tbl[i].d0, tbl[i].d1, 2'b00, 8'h00, 8'h00, tbl[i].exp_lat, 0);
        end

        // backpressure: 3 stalled cycles in RESP with requester 0 waiting
        exp_q.push_back({1'b1, 8'h61});
        do_txn(2'b10, 8'h00, 8'h6E, 2'b01, 8'h41, 8'h00, 5, 3);
        chk("bp_regrant", 8'(req_ready), 8'h01);
        exp_q.push_back({1'b0, 8'h4E});
        do_txn(2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 5, 0);

        // BYPASS_HI = 0: a high byte goes through the datapath and returns 0x00
        nb_req_data1 = 8'h9C; nb_req_valid = 2'b10; nb_rsp_ready = 1'b1;
        #1;
        chk("nb_req_ready", 8'(nb_req_ready), 8'h02);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) chk("nb_dp_lo", {nb_dp_ctl, 2'b00, nb_dp_data}, 8'h0C);
            if (k == 2) chk("nb_dp_hi", {nb_dp_ctl, 2'b00, nb_dp_data}, 8'h49);
            if (k < 5) chk("nb_rsp_valid_early", 8'(nb_rsp_valid), 8'h00);
            if (k == 5) begin
                chk("nb_rsp_valid", 8'(nb_rsp_valid), 8'h01);
                chk("nb_rsp_data", nb_rsp_data, 8'h00);
                chk("nb_rsp_id", 8'(nb_rsp_id), 8'h01);
            end
            if (k == 1) nb_req_valid = 2'b00;
        end
        @(negedge clk);
        chk("nb_busy_after", 8'(nb_busy), 8'h00);
        chk("nb_err", 8'(nb_err), 8'h00);
        nb_rsp_ready = 1'b0;

        // reset during CONV
        req_data0 = 8'h41; req_valid = 2'b01;
        #1;
        chk("rc_req_ready", 8'(req_ready), 8'h01);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("rc_conv_ctl", 8'(dp_ctl), 8'h02);
        chk("rc_conv_busy", 8'(busy), 8'h01);
        reset = 1'b1;
        #1;
        chk("rc_dp_rst_comb", 8'(dp_rst), 8'h01);
        @(negedge clk);
        chk("rc_busy", 8'(busy), 8'h00);
        chk("rc_rsp_valid", 8'(rsp_valid), 8'h00);
        chk("rc_rsp_data", rsp_data, 8'h00);
        chk("rc_dp_rst", 8'(dp_rst), 8'h01);
        reset = 1'b0;
        @(negedge clk);
        exp_q.push_back({1'b0, 8'h20});
        do_txn(2'b01, 8'h20, 8'h00, 2'b00, 8'h00, 8'h00, 5, 0);

        // corrupted acknowledge in HI
        corrupt_lo = 1'b1;
        exp_q.push_back({1'b0, ACK ? 8'h00 : 8'h4E});
        do_txn(2'b01, 8'h41, 8'h00, 2'b00, 8'h00, 8'h00, 5, 0);
        corrupt_lo = 1'b0;
        chk("ack_err", 8'(err), ACK ? 8'h01 : 8'h00);
        exp_q.push_back({1'b0, 8'h6E});
        do_txn(2'b01, 8'h61, 8'h00, 2'b00, 8'h00, 8'h00, 5, 0);
        chk("ack_err_sticky", 8'(err), ACK ? 8'h01 : 8'h00);
        reset_dut();
        chk("ack_err_cleared", 8'(err), 8'h00);

        // randomized traffic against the reference model
        m_last = 1'b1;
        pend = 2'b00; pd0 = 8'h00; pd1 = 8'h00;
        for (int it = 0; it < 60; it++) begin
            sv = 2'($urandom_range(0, 3)) & ~pend;
            if ((pend | sv) == 2'b00) sv = 2'b01;
            nd0 = rand_byte();
            nd1 = rand_byte();
            if (sv[0]) pd0 = nd0;
            if (sv[1]) pd1 = nd1;
            pend = pend | sv;
            gid = (pend == 2'b11) ? ~m_last : pend[1];
            bg  = gid ? pd1 : pd0;
            ex  = (BYP && bg[7]) ? bg : ref_rot13(bg);
            lat = (BYP && bg[7]) ? 1 : 5;
            pend[gid] = 1'b0;
            m_last = gid;
            lv  = 2'($urandom_range(0, 3)) & ~pend;
            ld0 = rand_byte();
            ld1 = rand_byte();
            if (lv[0]) pd0 = ld0;
            if (lv[1]) pd1 = ld1;
            pend = pend | lv;
            exp_q.push_back({gid, ex});
            do_txn(sv, nd0, nd1, lv, ld0, ld1, lat, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
